// File: rtl/game_flow_controller_pkg.sv
// Shared definitions for the round sequencer and the downstream score renderer.
// Holds the state encoding and the BCD score geometry.
package game_flow_controller_pkg;

  localparam int DIGIT_W    = 4;
  localparam int SCORE_W    = 16;
  localparam int NUM_DIGITS = SCORE_W / DIGIT_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    PLAYING   = 2'd2,
    GAME_OVER = 2'd3
  } state_e;

endpackage

// File: rtl/game_flow_controller_if.sv
// Signal bundle between the game datapath (master side) and the round sequencer (slave side).
// The master drives ticks, keys and detector results; the slave returns round status.
interface game_flow_controller_if;
  import game_flow_controller_pkg::*;

  logic               game_en;
  logic               start_n;
  logic               collision;
  logic               obstacle_missed;
  logic [9:0]         player_height;
  logic               play_en;
  state_e             state;
  logic [3:0]         countdown;
  logic [SCORE_W-1:0] score_bcd;
  logic [1:0]         lives;
  logic               win;

  modport master (
    output game_en, start_n, collision, obstacle_missed, player_height,
    input  play_en, state, countdown, score_bcd, lives, win
  );

  modport slave (
    input  game_en, start_n, collision, obstacle_missed, player_height,
    output play_en, state, countdown, score_bcd, lives, win
  );

endinterface

// File: rtl/game_flow_controller_bcd_score_counter.sv
// Four-digit BCD up-counter with synchronous clear, saturating at 9999.
// Each digit wraps 9->0 and passes a carry to the next more significant digit.
module bcd_score_counter
  import game_flow_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_inc,
  output logic [SCORE_W-1:0] o_value
);

  logic [SCORE_W-1:0] r_value;
  logic [SCORE_W-1:0] w_value_next;
  logic               w_carry;
  logic               w_saturated;

  assign w_saturated = (r_value == 16'h9999);

  // NOTE: always_comb gives every output a default before any branch, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_value_next = r_value;
    w_carry      = i_inc && !w_saturated;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (w_carry) begin
        if (r_value[d*DIGIT_W +: DIGIT_W] == 4'd9) begin
          w_value_next[d*DIGIT_W +: DIGIT_W] = 4'd0;
        end else begin
          w_value_next[d*DIGIT_W +: DIGIT_W] = r_value[d*DIGIT_W +: DIGIT_W] + 4'd1;
          w_carry = 1'b0;
        end
      end
    end
    if (i_clear) w_value_next = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_value <= '0;
    else     r_value <= w_value_next;
  end

  assign o_value = r_value;

endmodule

// File: rtl/game_flow_controller.sv
// Round sequencer: IDLE -> COUNTDOWN -> PLAYING -> GAME_OVER, with BCD scoring,
// lives tracking and a game tick gated to live play.
module game_flow_controller
  import game_flow_controller_pkg::*;
#(
  parameter logic [9:0] WIN_HEIGHT    = 10'd300,
  parameter logic [1:0] START_LIVES   = 2'd3,
  parameter logic [3:0] COUNT_SECONDS = 4'd3,
  parameter logic [7:0] TICKS_PER_SEC = 8'd60
) (
  input  logic                  clk,
  input  logic                  rst,
  game_flow_controller_if.slave bus
);

  logic   r_start_meta, r_start_sync, r_start_prev;
  logic   r_collision_q;
  state_e r_state, w_state_next;
  logic [3:0] r_countdown, w_countdown_next;
  logic [7:0] r_tick_cnt,  w_tick_next;
  logic [1:0] r_lives,     w_lives_next;
  logic   r_win, w_win_next;
  logic   w_press, w_col_edge, w_score_clear, w_score_inc;

  // start_n is asynchronous; two flops for metastability, a third for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_meta  <= 1'b1;
      r_start_sync  <= 1'b1;
      r_start_prev  <= 1'b1;
      r_collision_q <= 1'b0;
    end else begin
      r_start_meta  <= bus.start_n;
      r_start_sync  <= r_start_meta;
      r_start_prev  <= r_start_sync;
      r_collision_q <= bus.collision;
    end
  end

  assign w_press    = r_start_prev & ~r_start_sync;
  assign w_col_edge = bus.collision & ~r_collision_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_countdown <= 4'd0;
      r_tick_cnt  <= 8'd0;
      r_lives     <= 2'd0;
      r_win       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_countdown <= w_countdown_next;
      r_tick_cnt  <= w_tick_next;
      r_lives     <= w_lives_next;
      r_win       <= w_win_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_countdown_next = r_countdown;
    w_tick_next      = r_tick_cnt;
    w_lives_next     = r_lives;
    w_win_next       = r_win;
    w_score_clear    = 1'b0;
    w_score_inc      = 1'b0;
    unique case (r_state)
      IDLE, GAME_OVER: begin
        if (w_press) begin
          w_state_next     = COUNTDOWN;
          w_countdown_next = COUNT_SECONDS;
          w_tick_next      = 8'd0;
          w_lives_next     = START_LIVES;
          w_win_next       = 1'b0;
          w_score_clear    = 1'b1;
        end
      end
      COUNTDOWN: begin
        if (bus.game_en) begin
          if (r_tick_cnt == TICKS_PER_SEC - 8'd1) begin
            w_tick_next = 8'd0;
            if (r_countdown == 4'd1) begin
              w_state_next     = PLAYING;
              w_countdown_next = 4'd0;
            end else begin
              w_countdown_next = r_countdown - 4'd1;
            end
          end else begin
            w_tick_next = r_tick_cnt + 8'd1;
          end
        end
      end
      PLAYING: begin
        w_score_inc = w_col_edge;
        if (bus.obstacle_missed && r_lives != 2'd0) w_lives_next = r_lives - 2'd1;
        // A height win outranks running out of lives in the same cycle.
        if (bus.player_height >= WIN_HEIGHT) begin
          w_state_next = GAME_OVER;
          w_win_next   = 1'b1;
        end else if (bus.obstacle_missed && r_lives == 2'd1) begin
          w_state_next = GAME_OVER;
          w_win_next   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  bcd_score_counter u_score (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_score_clear),
    .i_inc   (w_score_inc),
    .o_value (bus.score_bcd)
  );

  assign bus.play_en   = bus.game_en & (r_state == PLAYING);
  assign bus.state     = r_state;
  assign bus.countdown = r_countdown;
  assign bus.lives     = r_lives;
  assign bus.win       = r_win;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller: round start, countdown, scoring,
// BCD carry/saturation, lives, exit priority and asynchronous reset.
module tb_game_flow_controller;
  import game_flow_controller_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   play_seen = 0;

  game_flow_controller_if bus ();

  game_flow_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_start();
    bus.start_n = 1'b0;
    step(5);
    bus.start_n = 1'b1;
    step(3);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.game_en = 1'b1;
      #1;
      if (bus.play_en) play_seen++;
      step(1);
      bus.game_en = 1'b0;
      step(1);
    end
  endtask

  task automatic collision_edges(input int n);
    repeat (n) begin
      bus.collision = 1'b1;
      step(1);
      bus.collision = 1'b0;
      step(1);
    end
  endtask

  task automatic miss();
    bus.obstacle_missed = 1'b1;
    step(1);
    bus.obstacle_missed = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    step(3);
    rst = 1'b0;
    step(2);
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    checks++; if (bus.countdown !== 4'd0) begin errors++; $display("FAIL reset_countdown: got %0d want 0", bus.countdown); end
    checks++; if (bus.score_bcd !== 16'h0000) begin errors++; $display("FAIL reset_score: got %h want 0000", bus.score_bcd); end
    checks++; if (bus.lives !== 2'd0) begin errors++; $display("FAIL reset_lives: got %0d want 0", bus.lives); end
    checks++; if (bus.win !== 1'b0) begin errors++; $display("FAIL reset_win: got %0d want 0", bus.win); end
    bus.game_en = 1'b1;
    #1;
    checks++; if (bus.play_en !== 1'b0) begin errors++; $display("FAIL reset_play_en: got %0d want 0", bus.play_en); end
    step(1);
    bus.game_en = 1'b0;
    step(1);
  endtask

  task automatic test_start();
    press_start();
    checks++; if (bus.state !== COUNTDOWN) begin errors++; $display("FAIL start_state: got %0d want 1", bus.state); end
    checks++; if (bus.countdown !== 4'd3) begin errors++; $display("FAIL start_countdown: got %0d want 3", bus.countdown); end
    checks++; if (bus.lives !== 2'd3) begin errors++; $display("FAIL start_lives: got %0d want 3", bus.lives); end
    checks++; if (bus.score_bcd !== 16'h0000) begin errors++; $display("FAIL start_score: got %h want 0000", bus.score_bcd); end
  endtask

  task automatic test_countdown();
    play_seen = 0;
    ticks(60);
    checks++; if (bus.countdown !== 4'd2) begin errors++; $display("FAIL cd_after_60: got %0d want 2", bus.countdown); end
    press_start();
    checks++; if (bus.countdown !== 4'd2) begin errors++; $display("FAIL cd_press_ignored: got %0d want 2", bus.countdown); end
    ticks(59);
    checks++; if (bus.countdown !== 4'd2) begin errors++; $display("FAIL cd_after_119: got %0d want 2", bus.countdown); end
    ticks(1);
    checks++; if (bus.countdown !== 4'd1) begin errors++; $display("FAIL cd_after_120: got %0d want 1", bus.countdown); end
    ticks(59);
    checks++; if (bus.state !== COUNTDOWN) begin errors++; $display("FAIL cd_state_179: got %0d want 1", bus.state); end
    ticks(1);
    checks++; if (bus.state !== PLAYING) begin errors++; $display("FAIL cd_state_180: got %0d want 2", bus.state); end
    checks++; if (bus.countdown !== 4'd0) begin errors++; $display("FAIL cd_countdown_180: got %0d want 0", bus.countdown); end
    checks++; if (play_seen !== 0) begin errors++; $display("FAIL cd_play_en_early: got %0d pulses want 0", play_seen); end
    bus.game_en = 1'b1;
    #1;
    checks++; if (bus.play_en !== 1'b1) begin errors++; $display("FAIL first_play_en: got %0d want 1", bus.play_en); end
    step(1);
    bus.game_en = 1'b0;
    step(1);
  endtask

  task automatic test_collision_hold();
    bus.collision = 1'b1;
    step(20);
    bus.collision = 1'b0;
    step(1);
    bus.collision = 1'b1;
    step(1);
    bus.collision = 1'b0;
    step(1);
    checks++; if (bus.score_bcd !== 16'h0002) begin errors++; $display("FAIL hold_score: got %h want 0002", bus.score_bcd); end
  endtask

  task automatic test_bcd_carry();
    collision_edges(7);
    checks++; if (bus.score_bcd !== 16'h0009) begin errors++; $display("FAIL carry_0009: got %h want 0009", bus.score_bcd); end
    collision_edges(1);
    checks++; if (bus.score_bcd !== 16'h0010) begin errors++; $display("FAIL carry_0010: got %h want 0010", bus.score_bcd); end
  endtask

  task automatic test_lives_loss();
    bus.player_height = 10'd30;
    miss();
    checks++; if (bus.lives !== 2'd2) begin errors++; $display("FAIL miss1_lives: got %0d want 2", bus.lives); end
    miss();
    checks++; if (bus.lives !== 2'd1) begin errors++; $display("FAIL miss2_lives: got %0d want 1", bus.lives); end
    checks++; if (bus.state !== PLAYING) begin errors++; $display("FAIL miss2_state: got %0d want 2", bus.state); end
    miss();
    checks++; if (bus.state !== GAME_OVER) begin errors++; $display("FAIL miss3_state: got %0d want 3", bus.state); end
    checks++; if (bus.win !== 1'b0) begin errors++; $display("FAIL miss3_win: got %0d want 0", bus.win); end
    checks++; if (bus.lives !== 2'd0) begin errors++; $display("FAIL miss3_lives: got %0d want 0", bus.lives); end
    collision_edges(3);
    miss();
    checks++; if (bus.score_bcd !== 16'h0010) begin errors++; $display("FAIL over_score_hold: got %h want 0010", bus.score_bcd); end
    checks++; if (bus.lives !== 2'd0) begin errors++; $display("FAIL over_lives_hold: got %0d want 0", bus.lives); end
    bus.game_en = 1'b1;
    #1;
    checks++; if (bus.play_en !== 1'b0) begin errors++; $display("FAIL over_play_en: got %0d want 0", bus.play_en); end
    step(1);
    bus.game_en = 1'b0;
    step(1);
  endtask

  task automatic test_new_round();
    press_start();
    checks++; if (bus.state !== COUNTDOWN) begin errors++; $display("FAIL restart_state: got %0d want 1", bus.state); end
    checks++; if (bus.score_bcd !== 16'h0000) begin errors++; $display("FAIL restart_score: got %h want 0000", bus.score_bcd); end
    checks++; if (bus.lives !== 2'd3) begin errors++; $display("FAIL restart_lives: got %0d want 3", bus.lives); end
    ticks(179);
    bus.collision = 1'b1;
    ticks(1);
    step(3);
    checks++; if (bus.state !== PLAYING) begin errors++; $display("FAIL restart_playing: got %0d want 2", bus.state); end
    checks++; if (bus.score_bcd !== 16'h0000) begin errors++; $display("FAIL held_collision_score: got %h want 0000", bus.score_bcd); end
    bus.collision = 1'b0;
    step(1);
  endtask

  task automatic test_saturation();
    collision_edges(99);
    checks++; if (bus.score_bcd !== 16'h0099) begin errors++; $display("FAIL sat_0099: got %h want 0099", bus.score_bcd); end
    collision_edges(1);
    checks++; if (bus.score_bcd !== 16'h0100) begin errors++; $display("FAIL sat_0100: got %h want 0100", bus.score_bcd); end
    collision_edges(9899);
    checks++; if (bus.score_bcd !== 16'h9999) begin errors++; $display("FAIL sat_9999: got %h want 9999", bus.score_bcd); end
    collision_edges(1);
    checks++; if (bus.score_bcd !== 16'h9999) begin errors++; $display("FAIL sat_hold: got %h want 9999", bus.score_bcd); end
  endtask

  task automatic test_simultaneous_exit();
    bus.player_height = 10'd30;
    miss();
    miss();
    checks++; if (bus.lives !== 2'd1) begin errors++; $display("FAIL sim_pre_lives: got %0d want 1", bus.lives); end
    bus.player_height   = 10'd300;
    bus.obstacle_missed = 1'b1;
    step(1);
    bus.obstacle_missed = 1'b0;
    bus.player_height   = 10'd30;
    step(1);
    checks++; if (bus.state !== GAME_OVER) begin errors++; $display("FAIL sim_state: got %0d want 3", bus.state); end
    checks++; if (bus.win !== 1'b1) begin errors++; $display("FAIL sim_win: got %0d want 1", bus.win); end
    checks++; if (bus.lives !== 2'd0) begin errors++; $display("FAIL sim_lives: got %0d want 0", bus.lives); end
  endtask

  task automatic test_async_reset();
    press_start();
    ticks(180);
    collision_edges(42);
    checks++; if (bus.score_bcd !== 16'h0042) begin errors++; $display("FAIL pre_rst_score: got %h want 0042", bus.score_bcd); end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL arst_state: got %0d want 0", bus.state); end
    checks++; if (bus.score_bcd !== 16'h0000) begin errors++; $display("FAIL arst_score: got %h want 0000", bus.score_bcd); end
    checks++; if (bus.lives !== 2'd0) begin errors++; $display("FAIL arst_lives: got %0d want 0", bus.lives); end
    step(1);
    rst = 1'b0;
    step(2);
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL post_rst_state: got %0d want 0", bus.state); end
  endtask

  initial begin
    bus.game_en         = 1'b0;
    bus.start_n         = 1'b1;
    bus.collision       = 1'b0;
    bus.obstacle_missed = 1'b0;
    bus.player_height   = 10'd0;
    test_reset();
    test_start();
    test_countdown();
    test_collision_hold();
    test_bcd_carry();
    test_lives_loss();
    test_new_round();
    test_saturation();
    test_simultaneous_exit();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Round-level sequencer sitting downstream of the collision detector and player height manager, and upstream of the movement/obstacle stages.
- Runs IDLE -> COUNTDOWN -> PLAYING -> GAME_OVER.
- Counts catches as a 4-digit BCD score and tracks remaining lives from missed obstacles.
- Gates the game tick so player/obstacle logic only advances while a round is live.

Parameters:
- WIN_HEIGHT, 10'd300, player stack height at or above which the round is won.
- START_LIVES, 2'd3, lives loaded at round start (1..3).
- COUNT_SECONDS, 4'd3, countdown start value (1..9).
- TICKS_PER_SEC, 8'd60, game_en pulses per countdown step (>=1).

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset, asynchronous, active-high.
- game_en  in  1  single-cycle game tick from the game clock generator.
- start_n  in  1  raw start key, active-low, asynchronous to clk.
- collision  in  1  level from collision detector; high while player overlaps obstacle.
- obstacle_missed  in  1  single-cycle pulse when an obstacle exits the bottom uncaught.
- player_height  in  10  current stack height from height manager.
- play_en  out  1  game_en qualified by state==PLAYING (combinational, zero latency).
- state  out  2  0 IDLE, 1 COUNTDOWN, 2 PLAYING, 3 GAME_OVER.
- countdown  out  4  remaining countdown digit; 0 outside COUNTDOWN.
- score_bcd  out  16  four BCD digits, [15:12] most significant.
- lives  out  2  remaining lives.
- win  out  1  valid in GAME_OVER: 1 = height win, 0 = out of lives.

Behaviour:
- Reset values: state=IDLE, countdown=0, score_bcd=0, lives=0, win=0, tick counter=0, collision_q=0, start sync flops=1.
- Clock/reset: one clock, clk. Reset rst is asynchronous and active-high. Asserting rst mid-round returns immediately to IDLE with all registers at reset values.
- start_n passes through a 2-flop synchronizer.
- press = synced value 1 in previous cycle and 0 in current cycle (falling edge), one cycle wide.
- Press is honoured only in IDLE and GAME_OVER; ignored elsewhere, which also absorbs bounce.
- IDLE or GAME_OVER on press:
  - next state COUNTDOWN; countdown=COUNT_SECONDS; tick counter=0; score_bcd=0; win=0.
  - lives=START_LIVES, loaded here so the display is valid during countdown.
- COUNTDOWN: each game_en increments the tick counter.
  - When the counter == TICKS_PER_SEC-1 on a game_en, the counter clears and countdown decrements.
  - If countdown was 1 on that decrement, the next state is PLAYING and countdown becomes 0.
  - collision and obstacle_missed are ignored.
- PLAYING:
  - collision_q samples collision every cycle in all states. A rising edge (collision & ~collision_q) while PLAYING increments score_bcd by 1 with decimal carry. Score saturates at 9999.
  - obstacle_missed while PLAYING decrements lives (no underflow below 0).
  - Exit conditions, evaluated on the registered inputs of the same cycle:
    - player_height >= WIN_HEIGHT -> GAME_OVER, win=1.
    - lives==1 and obstacle_missed -> GAME_OVER, win=0.
  - If both exit conditions occur in the same cycle, win=1 takes priority. The lives decrement still applies, so lives=0.
  - A collision edge and a miss in the same cycle both apply.
- GAME_OVER: score_bcd, lives and win hold; play_en=0; only a press leaves this state.
- play_en = game_en & (state==PLAYING), using the current registered state. The first PLAYING tick is the first game_en after the transition cycle.
- All outputs except play_en are registered; updates are visible the cycle after the causing event.
- A collision held high across the COUNTDOWN->PLAYING transition scores nothing, because collision_q already tracks it.

Decomposition:
- Shared package:
  - state encoding constants IDLE/COUNTDOWN/PLAYING/GAME_OVER (2 bits).
  - BCD digit width (4) and score width (16), reused by the future 7-segment/score renderer.
- One sub-module: bcd_score_counter.
  - Inputs: clk, rst, clear, inc.
  - Output: 16-bit saturating 4-digit BCD value.
  - Contains the per-digit carry chain.

Test Plan:
- Reset then press start_n (low for 5 cycles) -> state=1, countdown=3, lives=3, score=0. After 180 game_en pulses -> state=2, countdown=0. play_en pulses only after the transition.
- In PLAYING, collision high for 20 cycles, low, high again for 1 cycle -> score_bcd=16'h0002, not 21 or 22.
- Drive 9 then 1 more collision edges from score 0009 -> 0010. Preload to 9999 via 9999 edges, then one more edge -> stays 16'h9999.
- Three obstacle_missed pulses with height 30 -> lives 3,2,1, then state=3, win=0, lives=0. Further collisions leave score unchanged, play_en=0.
- Same cycle: player_height=300, obstacle_missed=1, lives=1 -> state=3, win=1, lives=0.
- Assert rst for 1 cycle mid-PLAYING with score 0042 -> state=0, score=0, lives=0 asynchronously. Press during COUNTDOWN -> countdown not reloaded.
